// File: rtl/inst_fetch.sv
// Fetch stage: direct-mapped 64-byte-line cache, static JAL prediction, queue to the decoder.
// Hit pushes one entry per cycle, visible next cycle; misses stall until fill; full queue stalls the PC.
module inst_fetch #(
    parameter int          LINE_NUM = 4,
    parameter int          IQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         rollback,
    input  logic [31:0]  rollback_pc,
    output logic         mem_inst_config,
    output logic [31:0]  mem_inst_pc,
    input  logic [511:0] mem_inst_row,
    input  logic         mem_inst_done,
    input  logic         iq_pop,
    output logic         iq_valid,
    output logic [31:0]  iq_inst,
    output logic [31:0]  iq_pc,
    output logic [31:0]  iq_pred_pc
);
    localparam int IDX_W = $clog2(LINE_NUM);
    localparam int TAG_W = 26 - IDX_W;
    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {FETCH, MISS} state_t;

    state_t              state;
    logic [31:0]         pc;
    logic [LINE_NUM-1:0] line_vld;
    logic [TAG_W-1:0]    tag_mem  [LINE_NUM];
    logic [511:0]        line_mem [LINE_NUM];

    logic [31:0]         q_inst [IQ_DEPTH];
    logic [31:0]         q_pc   [IQ_DEPTH];
    logic [31:0]         q_pred [IQ_DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;

    logic [IDX_W-1:0]    index;
    logic [TAG_W-1:0]    tag;
    logic [3:0]          word;
    logic [511:0]        cur_line;
    logic [31:0]         inst;
    logic [31:0]         jal_imm;
    logic [31:0]         pred_pc;
    logic                hit;
    logic                do_pop;
    logic                push_ok;
    logic                do_push;
    logic                do_fill;

    assign index    = pc[5+IDX_W:6];
    assign tag      = pc[31:6+IDX_W];
    assign word     = pc[5:2];
    assign cur_line = line_mem[index];
    assign hit      = line_vld[index] && (tag_mem[index] == tag);
    assign inst     = cur_line[{word, 5'b00000} +: 32];

    // J-type immediate; bit 31 is the sign and also imm[20]
    assign jal_imm  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign pred_pc  = (inst[6:0] == 7'b1101111) ? pc + jal_imm : pc + 32'd4;

    assign iq_valid   = (count != '0);
    assign iq_inst    = q_inst[head];
    assign iq_pc      = q_pc[head];
    assign iq_pred_pc = q_pred[head];

    assign do_pop  = rdy && iq_pop && iq_valid;
    assign push_ok = (count < CNT_W'(IQ_DEPTH)) || do_pop;
    assign do_push = rdy && !rollback && (state == FETCH) && hit && push_ok;
    assign do_fill = rdy && !rollback && (state == MISS) && mem_inst_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc              <= RESET_PC;
            line_vld        <= '0;
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            mem_inst_config <= 1'b0;
            mem_inst_pc     <= 32'h0;
            state           <= FETCH;
        end else if (rdy) begin
            if (rollback) begin
                head            <= '0;
                tail            <= '0;
                count           <= '0;
                pc              <= rollback_pc;
                mem_inst_config <= 1'b0;
                state           <= FETCH;
            end else begin
                if (do_push) begin
                    tail <= tail + PTR_W'(1);
                    pc   <= pred_pc;
                end
                if (do_pop) begin
                    head <= head + PTR_W'(1);
                end
                if (do_push && !do_pop) begin
                    count <= count + CNT_W'(1);
                end else if (!do_push && do_pop) begin
                    count <= count - CNT_W'(1);
                end
                case (state)
                    FETCH: begin
                        if (!hit) begin
                            mem_inst_config <= 1'b1;
                            mem_inst_pc     <= {pc[31:6], 6'b0};
                            state           <= MISS;
                        end
                    end
                    MISS: begin
                        if (mem_inst_done) begin
                            line_vld[index] <= 1'b1;
                            mem_inst_config <= 1'b0;
                            state           <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

    // Line data and tags need no reset: the valid bits gate every use
    always_ff @(posedge clk) begin
        if (!rst && do_fill) begin
            line_mem[index] <= mem_inst_row;
            tag_mem[index]  <= tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            q_inst[tail] <= inst;
            q_pc[tail]   <= pc;
            q_pred[tail] <= pred_pc;
        end
    end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage directly upstream of the decoder and a client of the memory controller's instruction port. Holds a small direct-mapped cache of 64-byte lines filled by the memory controller, walks the PC with static JAL prediction, and pushes {inst, pc, pred_pc} into an instruction queue for the decoder. A rollback from the reorder buffer flushes the queue and redirects the PC.

Parameters:
LINE_NUM, 4, number of cached 64-byte lines; power of two, at least 2.
IQ_DEPTH, 4, instruction queue entries; power of two, at least 2.
RESET_PC, 32'h0, PC loaded on reset.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
rdy  input  1  global enable; when low, all state holds
rollback  input  1  ROB misprediction flush
rollback_pc  input  32  redirect target; valid when rollback=1
mem_inst_config  output  1  line fetch request to the memory controller (registered)
mem_inst_pc  output  32  line-aligned request address, low 6 bits always zero (registered)
mem_inst_row  input  512  fetched line; byte i at bits [8i+7:8i]
mem_inst_done  input  1  one-cycle pulse; mem_inst_row is valid in this cycle
iq_pop  input  1  decoder consumes the head entry
iq_valid  output  1  queue non-empty
iq_inst  output  32  head instruction
iq_pc  output  32  head PC
iq_pred_pc  output  32  head predicted next PC

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst. Both are fixed.
- Reset: pc=RESET_PC, all line valid bits=0, queue head/tail/count=0, mem_inst_config=0, mem_inst_pc=0, state=FETCH.
- Reset has priority over everything else, including mid-miss: the pending request drops and no line is written.
- Cache addressing:
  - index = pc[5+log2(LINE_NUM):6]
  - tag = pc[31:6+log2(LINE_NUM)]
  - word = pc[5:2]
  - inst = line[word*32 +: 32], little-endian
- PC is always 4-aligned, so a fetch never crosses a line. Valid bits clear only on reset, never on rollback.
- The iq_* outputs are combinational from the head entry. iq_valid = (count != 0).
- Queue pop: occurs when rdy && iq_pop && iq_valid.
- Queue push: allowed when count < IQ_DEPTH, or when a pop occurs in the same cycle. Simultaneous push and pop at full leaves count unchanged. Pointers wrap modulo IQ_DEPTH.
- Prediction:
  - If inst[6:0]==7'b1101111 (JAL): pred_pc = pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - Otherwise: pred_pc = pc + 4.
  - 32-bit wrap-around.
- FSM, evaluated only when rdy=1:
  - FETCH, hit (valid && tag match), push allowed: push {inst, pc, pred_pc}; pc <= pred_pc. Entry is visible on iq_valid the next cycle. Sustained throughput is 1 instr/cycle.
  - FETCH, hit, queue full with no pop: stall; pc holds.
  - FETCH, miss: mem_inst_config <= 1; mem_inst_pc <= {pc[31:6],6'b0}; state <= MISS.
  - MISS: request and address are held stable until mem_inst_done. On mem_inst_done: write the line, set the tag, set valid at the index; mem_inst_config <= 0; state <= FETCH. The hit lookup occurs the next cycle.
- Rollback (rdy=1) has priority over fetch, pop and fill in the same cycle:
  - queue count/head/tail <= 0; pc <= rollback_pc; mem_inst_config <= 0; state <= FETCH.
  - A fill completing in the same cycle is discarded and not written.
  - The first post-rollback push occurs at the earliest on the following cycle.
- rdy low: no push, pop, fill or PC update. Registered outputs hold. mem_inst_done is ignored.
- Miss latency: 1 cycle to raise the request, plus memory time, plus 1 cycle for lookup, plus 1 cycle to iq_valid.

Test Plan:
- Cold start, RESET_PC=0, memory holds ADDI words at 0x00..0x3C: mem_inst_config=1 with mem_inst_pc=0 the cycle after reset release. After mem_inst_done, 16 consecutive pushes occur with iq_pc=0,4,...,0x3C and iq_pred_pc=iq_pc+4. Then a second request appears with mem_inst_pc=0x40.
- JAL at 0x08 with encoding 0x0100006F (imm=+16): the entry shows iq_pred_pc=0x18, and the next pushed iq_pc is 0x18. JAL 0xFF9FF06F at 0x10 (imm=-8) gives pred_pc 0x08.
- Queue full: iq_pop held 0, hit stream with IQ_DEPTH=4. Exactly 4 pushes occur, then the PC stalls. A single iq_pop pulse gives exactly one further push, and count stays at 4.
- Rollback mid-miss: rollback=1 with rollback_pc=0x80 in the same cycle as mem_inst_done for line 0x40. The line is not marked valid, the queue is empty next cycle, and a new request appears with mem_inst_pc=0x80.
- Conflict eviction (LINE_NUM=4): fetch 0x000, then 0x100 (same index 0), then jump back to 0x000. A third request with mem_inst_pc=0x000 is issued.
- rdy low for 5 cycles during a hit stream with iq_pop=1: iq_pc, count and pc are unchanged, and the stream resumes with the next sequential PC when rdy returns.
